// File: rtl/dz_pkg.sv
// Shared types and default constants for the dot-matrix frame selector.
package dz_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHOW   = 3'd1,
        ST_SPIN   = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } dz_state_e;

    // Column-drive and status flags, registered together as one payload.
    typedef struct packed {
        logic red_en;
        logic grn_en;
        logic img_valid;
        logic spinning;
    } dz_flags_t;

    localparam int unsigned DEF_HATCH_CODE  = 16;
    localparam int unsigned DEF_ANIMAL_BASE = 8;
    localparam int unsigned DEF_LFSR_W      = 8;

    // Right-shifting Galois mask for x^8+x^6+x^5+x^4+1.
    localparam logic [7:0] DEF_LFSR_TAPS = 8'hB8;
    localparam logic [7:0] DEF_SEED      = 8'hA5;

endpackage : dz_pkg

// File: rtl/dz_lfsr.sv
// Free-running right-shifting Galois LFSR; reloads SEED on reset.
module dz_lfsr #(
    parameter int unsigned W    = 8,
    parameter logic [W-1:0] TAPS = 8'hB8,
    parameter logic [W-1:0] SEED = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    always_comb begin
        state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule : dz_lfsr

// File: rtl/dz_frame_sel.sv
// Maps game stage codes to dot-matrix frame indices, with a timed animal
// spin on the hatch code and a green recolour while the game is failed.
module dz_frame_sel
    import dz_pkg::*;
#(
    parameter int unsigned NUM_W       = 5,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned STAGE_SHIFT = 1,
    parameter int unsigned HATCH_CODE  = DEF_HATCH_CODE,
    parameter int unsigned ANIMAL_BASE = DEF_ANIMAL_BASE,
    parameter int unsigned N_ANIMALS   = 4,
    parameter int unsigned SPIN_STEPS  = 8,
    parameter int unsigned HOLD_CYC    = 4,
    parameter int unsigned LFSR_W      = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEF_SEED),
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_LFSR_TAPS),
    localparam int unsigned ANIM_W = (N_ANIMALS > 1) ? $clog2(N_ANIMALS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [NUM_W-1:0]  dz_num_i,
    input  logic              fail_i,
    output logic [IDX_W-1:0]  img_idx_o,
    output logic              red_en_o,
    output logic              grn_en_o,
    output logic              img_valid_o,
    output logic              spinning_o,
    output logic [ANIM_W-1:0] animal_o
);

    localparam int unsigned STEP_W = $clog2(SPIN_STEPS + 1);
    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [NUM_W-1:0]  HATCH_V   = NUM_W'(HATCH_CODE);
    localparam logic [IDX_W-1:0]  BASE_V    = IDX_W'(ANIMAL_BASE);
    localparam logic [STEP_W-1:0] STEPS_V   = STEP_W'(SPIN_STEPS);
    localparam logic [STEP_W-1:0] STEP_MASK = STEP_W'(N_ANIMALS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [LFSR_W-1:0] ANIM_MASK = LFSR_W'(N_ANIMALS - 1);

    dz_state_e         state_q,  state_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    dz_flags_t         flags_q,  flags_d;
    logic [ANIM_W-1:0] animal_q, animal_d;
    logic [STEP_W-1:0] step_q,   step_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;

    logic [STEP_W-1:0] step_inc;
    logic [LFSR_W-1:0] lfsr_q;
    logic [ANIM_W-1:0] lfsr_pick;
    logic              is_stage;
    logic              is_hatch;

    dz_lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .state_o (lfsr_q)
    );

    // Codes above the hatch code fall through both decodes and are ignored.
    assign is_stage  = load_i && (dz_num_i <  HATCH_V);
    assign is_hatch  = load_i && (dz_num_i == HATCH_V);
    assign step_inc  = step_q + STEP_W'(1);
    assign lfsr_pick = ANIM_W'(lfsr_q & ANIM_MASK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            flags_q  <= '0;
            animal_q <= '0;
            step_q   <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            flags_q  <= flags_d;
            animal_q <= animal_d;
            step_q   <= step_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        flags_d  = flags_q;
        animal_d = animal_q;
        step_d   = step_q;
        hold_d   = hold_q;

        if (fail_i) begin
            // Freeze on the current frame and recolour it green.
            state_d           = ST_FAIL;
            flags_d.red_en    = 1'b0;
            flags_d.grn_en    = 1'b1;
            flags_d.img_valid = 1'b1;
            flags_d.spinning  = 1'b0;
        end else if (state_q == ST_FAIL) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            flags_d  = '0;
            animal_d = '0;
            step_d   = '0;
            hold_d   = '0;
        end else if (is_stage) begin
            state_d           = ST_SHOW;
            idx_d             = IDX_W'(dz_num_i >> STAGE_SHIFT);
            flags_d.red_en    = 1'b1;
            flags_d.grn_en    = 1'b0;
            flags_d.img_valid = 1'b1;
            flags_d.spinning  = 1'b0;
            step_d            = '0;
            hold_d            = '0;
        end else if (is_hatch) begin
            state_d           = ST_SPIN;
            idx_d             = BASE_V;
            flags_d.red_en    = 1'b1;
            flags_d.grn_en    = 1'b0;
            flags_d.img_valid = 1'b0;
            flags_d.spinning  = 1'b1;
            step_d            = '0;
            hold_d            = '0;
        end else if (state_q == ST_SPIN) begin
            if (hold_q == HOLD_LAST) begin
                hold_d = '0;
                step_d = step_inc;
                if (step_inc == STEPS_V) begin
                    // Spin finished: lock onto the LFSR-chosen animal.
                    state_d           = ST_LOCKED;
                    animal_d          = lfsr_pick;
                    idx_d             = BASE_V + IDX_W'(lfsr_pick);
                    flags_d.spinning  = 1'b0;
                    flags_d.img_valid = 1'b1;
                end else begin
                    idx_d = BASE_V + IDX_W'(step_inc & STEP_MASK);
                end
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    assign img_idx_o   = idx_q;
    assign red_en_o    = flags_q.red_en;
    assign grn_en_o    = flags_q.grn_en;
    assign img_valid_o = flags_q.img_valid;
    assign spinning_o  = flags_q.spinning;
    assign animal_o    = animal_q;

endmodule : dz_frame_sel
